// File: rtl/data_mem_pkg.sv
// Shared address map for the core's data-side responder.
// RAM/MMIO region bases, MMIO register offsets and STATUS bit positions.
package data_mem_pkg;

  localparam logic [3:0]  RAM_REGION = 4'h0;
  localparam logic [23:0] MMIO_BASE  = 24'hF00000;

  localparam logic [7:0] OFS_TIMER     = 8'h00;
  localparam logic [7:0] OFS_TIMER_CMP = 8'h04;
  localparam logic [7:0] OFS_STATUS    = 8'h08;
  localparam logic [7:0] OFS_TX_DATA   = 8'h0C;
  localparam logic [7:0] OFS_GPIO_OUT  = 8'h10;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_MATCH = 2;

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO for the console transmitter; push visible at the head one cycle later.
// Push into a full FIFO is dropped unless a pop happens at the same edge.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       push_i,
  input  logic [7:0] push_dat_i,
  input  logic       pop_i,
  output logic [7:0] head_dat_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Extra pointer bit separates the full and empty cases when indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
  end

endmodule

// File: rtl/data_mem_subsystem.sv
// Data-side responder: word RAM plus timer/GPIO/console MMIO; loads are combinational.
// Stores commit on the edge; console bytes drain by tx_valid/tx_ready, overflow pushes drop.
module data_mem_subsystem
  import data_mem_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] data_memory_addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] gpio_out,
  output logic        timer_irq
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  logic [31:0] ram_q [RAM_WORDS];
  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] gpio_q, gpio_d;
  logic        match_q, match_d;

  logic             ram_sel, mmio_sel, wr_en;
  logic [7:0]       ofs;
  logic [IDX_W-1:0] ram_idx;
  logic             cmp_we, gpio_we, match_clr, tx_push;
  logic             fifo_full, fifo_empty;
  logic [31:0]      status;

  assign ram_sel  = (data_memory_addr[31:28] == RAM_REGION);
  assign mmio_sel = (data_memory_addr[31:8] == MMIO_BASE);
  assign ofs      = data_memory_addr[7:0];
  assign ram_idx  = data_memory_addr[IDX_W+1:2];
  assign wr_en    = mem_write && reset;

  assign cmp_we    = wr_en && mmio_sel && (ofs == OFS_TIMER_CMP);
  assign gpio_we   = wr_en && mmio_sel && (ofs == OFS_GPIO_OUT);
  assign match_clr = wr_en && mmio_sel && (ofs == OFS_STATUS) && write_data[ST_MATCH];
  assign tx_push   = wr_en && mmio_sel && (ofs == OFS_TX_DATA);

  always_ff @(posedge clk) begin
    if (wr_en && ram_sel) ram_q[ram_idx] <= write_data;
  end

  always_comb begin
    timer_d = timer_q + 32'd1;
    cmp_d   = cmp_we ? write_data : cmp_q;
    gpio_d  = gpio_we ? write_data : gpio_q;
    // A match on the same edge as a W1C clear keeps the flag set.
    match_d = (timer_q == cmp_q) || (match_q && !match_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      gpio_q  <= '0;
      match_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      cmp_q   <= cmp_d;
      gpio_q  <= gpio_d;
      match_q <= match_d;
    end
  end

  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i      (clk),
    .reset_ni   (reset),
    .push_i     (tx_push),
    .push_dat_i (write_data[7:0]),
    .pop_i      (tx_ready),
    .head_dat_o (tx_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign tx_valid  = !fifo_empty;
  assign gpio_out  = gpio_q;
  assign timer_irq = match_q;

  always_comb begin
    status           = '0;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_MATCH] = match_q;
  end

  always_comb begin
    read_data = '0;
    if (ram_sel) begin
      read_data = ram_q[ram_idx];
    end else if (mmio_sel) begin
      case (ofs)
        OFS_TIMER:     read_data = timer_q;
        OFS_TIMER_CMP: read_data = cmp_q;
        OFS_STATUS:    read_data = status;
        OFS_GPIO_OUT:  read_data = gpio_q;
        default:       read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_subsystem.sv
// Directed bench for data_mem_subsystem: RAM, reset, console FIFO, timer match, reset mid-drain.
module tb_data_mem_subsystem;

  localparam logic [31:0] A_TIMER  = 32'hF000_0000;
  localparam logic [31:0] A_CMP    = 32'hF000_0004;
  localparam logic [31:0] A_STATUS = 32'hF000_0008;
  localparam logic [31:0] A_TX     = 32'hF000_000C;
  localparam logic [31:0] A_GPIO   = 32'hF000_0010;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [31:0] data_memory_addr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] gpio_out;
  logic        timer_irq;

  int errors = 0;
  int checks = 0;

  data_mem_subsystem #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_write        (mem_write),
    .data_memory_addr (data_memory_addr),
    .write_data       (write_data),
    .read_data        (read_data),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .gpio_out         (gpio_out),
    .timer_irq        (timer_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    data_memory_addr = a;
    write_data       = d;
    mem_write        = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    data_memory_addr = a;
    #1;
    d = read_data;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b0;
    step();
    reset = 1'b1;
    rd(A_TIMER, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_timer: got %h want %h", d, 32'd0); end
    rd(A_STATUS, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL reset_status: got %h want %h", d, 32'h2); end
    checks++; if (gpio_out !== 32'd0) begin errors++; $display("FAIL reset_gpio: got %h want 0", gpio_out); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", timer_irq); end
    repeat (3) step();
    rd(A_TIMER, d);
    checks++; if (d !== 32'd3) begin errors++; $display("FAIL reset_timer3: got %h want %h", d, 32'd3); end
  endtask

  task automatic test_ram();
    logic [31:0] d;
    do_write(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_load: got %h want DEADBEEF", d); end
    rd(32'h13, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_unaligned: got %h want DEADBEEF", d); end
    rd(32'h110, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_alias: got %h want DEADBEEF", d); end
    do_write(32'h14, 32'h1234_5678);
    do_write(32'h2000_0010, 32'h0BAD_0BAD);
    rd(32'h14, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_word2: got %h want 12345678", d); end
    rd(32'h10, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_unmapped_wr: got %h want DEADBEEF", d); end
    rd(32'h2000_0010, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL unmapped_read: got %h want 0", d); end
  endtask

  task automatic test_fifo_fill_drain();
    logic [31:0] d;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_write(A_TX, 32'h41 + i);
      if (i == 3) begin
        rd(A_STATUS, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL fifo_full_after4: got %h want 1", d); end
      end
    end
    rd(A_STATUS, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL fifo_full_after5: got %h want 1", d); end
    rd(A_TX, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL tx_data_reg_read: got %h want 0", d); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        errors++;
        $display("FAIL drain_byte%0d: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      step();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid: got %b want 0", tx_valid); end
    rd(A_STATUS, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL drain_empty_status: got %h want 2", d); end
    tx_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    logic [7:0]  exp_b [4];
    exp_b[0] = 8'h62; exp_b[1] = 8'h63; exp_b[2] = 8'h64; exp_b[3] = 8'h55;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_write(A_TX, 32'h61 + i);
    tx_ready = 1'b1;
    do_write(A_TX, 32'h55);
    tx_ready = 1'b0;
    rd(A_STATUS, d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL pushpop_still_full: got %h want 1", d); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        errors++;
        $display("FAIL pushpop_byte%0d: got valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, exp_b[i]);
      end
      step();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL pushpop_empty: got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_timer_match();
    logic [31:0] d;
    logic [31:0] t;
    bit          found;
    reset = 1'b0;
    step();
    reset = 1'b1;
    rd(A_TIMER, t);
    do_write(A_TIMER, 32'h0000_1234);
    rd(A_TIMER, d);
    checks++; if (d !== t + 32'd1) begin errors++; $display("FAIL timer_ro: got %h want %h", d, t + 32'd1); end
    do_write(A_CMP, 32'd20);
    rd(A_CMP, d);
    checks++; if (d !== 32'd20) begin errors++; $display("FAIL cmp_readback: got %h want %h", d, 32'd20); end
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      rd(A_TIMER, d);
      if (d == 32'd20) found = 1'b1;
      else step();
    end
    checks++; if (!found) begin errors++; $display("FAIL timer_reach20: got timeout want timer=20"); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_before_match: got %b want 0", timer_irq); end
    step();
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", timer_irq); end
    repeat (5) step();
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_sticky: got %b want 1", timer_irq); end
    rd(A_STATUS, d);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL status_match: got %h want 6", d); end
    do_write(A_STATUS, 32'h4);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", timer_irq); end
    rd(A_TIMER, t);
    do_write(A_CMP, t + 32'd5);
    repeat (4) step();
    rd(A_TIMER, d);
    checks++; if (d !== t + 32'd5) begin errors++; $display("FAIL timer_align: got %h want %h", d, t + 32'd5); end
    do_write(A_STATUS, 32'h4);
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL set_beats_clear: got %b want 1", timer_irq); end
    do_write(A_STATUS, 32'h4);
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_clear2: got %b want 0", timer_irq); end
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] d;
    do_write(A_GPIO, 32'hA5);
    checks++; if (gpio_out !== 32'hA5) begin errors++; $display("FAIL gpio_out: got %h want A5", gpio_out); end
    rd(A_GPIO, d);
    checks++; if (d !== 32'hA5) begin errors++; $display("FAIL gpio_read: got %h want A5", d); end
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_write(A_TX, 32'h71 + i);
    tx_ready = 1'b1;
    step();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h72) begin errors++; $display("FAIL middrain_head: got valid=%b data=%h want valid=1 data=72", tx_valid, tx_data); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL middrain_valid: got %b want 0", tx_valid); end
    rd(A_STATUS, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL middrain_status: got %h want 2", d); end
    rd(A_GPIO, d);
    checks++; if (d !== 32'd0 || gpio_out !== 32'd0) begin errors++; $display("FAIL middrain_gpio: got read=%h out=%h want 0", d, gpio_out); end
    tx_ready = 1'b0;
  endtask

  initial begin
    reset            = 1'b0;
    mem_write        = 1'b0;
    data_memory_addr = '0;
    write_data       = '0;
    tx_ready         = 1'b0;
    test_reset();
    test_ram();
    test_fifo_fill_drain();
    test_full_push_pop();
    test_timer_match();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
